// File: rtl/debug_run_ctrl.sv
// Run-control sequencer: host RUN/STEP/HALT/CLR in, pipeline enable out,
// with breakpoint / end-of-program stops, stop cause and cycle counter.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_cmd_valid      command strobe
//   i_cmd            00 RUN, 01 STEP, 10 HALT, 11 CLR
//   i_step_count     STEP length (0 treated as 1)
//   i_brk_enb        breakpoint compare enable
//   i_brk_pc         breakpoint address
//   i_pc             pipeline fetch PC
//   i_halt_instr     HALT instruction retired
//   o_pipe_enb       registered pipeline enable
//   o_cmd_ready      RUN/STEP/CLR accepted (IDLE, FINISH)
//   o_busy           same as o_pipe_enb
//   o_done           one-cycle pulse when a run ends
//   o_stop_cause     00 host, 01 steps, 10 brk, 11 end of program
//   o_cycle_cnt      saturating count of enabled cycles
module debug_run_ctrl #(
  parameter int NB_PC   = 32,
  parameter int NB_STEP = 16,
  parameter int NB_CYC  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  input  logic [NB_STEP-1:0] i_step_count,
  input  logic               i_brk_enb,
  input  logic [NB_PC-1:0]   i_brk_pc,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic               i_halt_instr,
  output logic               o_pipe_enb,
  output logic               o_cmd_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_stop_cause,
  output logic [NB_CYC-1:0]  o_cycle_cnt
);

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  localparam logic [1:0] CS_HOST = 2'b00;
  localparam logic [1:0] CS_STEP = 2'b01;
  localparam logic [1:0] CS_BRK  = 2'b10;
  localparam logic [1:0] CS_END  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic               enb_q, enb_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d;
  logic [NB_CYC-1:0]  cnt_q, cnt_d;
  logic [NB_STEP-1:0] rem_q, rem_d;
  logic               mask_q, mask_d;

  logic brk_hit;
  logic host_halt;
  logic [NB_STEP-1:0] step_ld;

  // mask_q suppresses the compare for the first enabled cycle of a run
  assign brk_hit   = i_brk_enb && (i_pc == i_brk_pc) && !mask_q;
  assign host_halt = i_cmd_valid && (i_cmd == CMD_HALT);
  assign step_ld   = (i_step_count == '0) ?
                     NB_STEP'(1) : i_step_count;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mask_d  = mask_q;

    if (enb_q) begin
      mask_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (state_q == S_STEP) rem_d = rem_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          unique case (i_cmd)
            CMD_RUN: begin
              state_d = S_RUN;
              mask_d  = 1'b1;
            end
            CMD_STEP: begin
              state_d = S_STEP;
              rem_d   = step_ld;
              mask_d  = 1'b1;
            end
            CMD_CLR:  cnt_d = '0;
            CMD_HALT: ;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        if (i_halt_instr) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          cause_d = CS_END;
        end else if (brk_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cause_d = CS_BRK;
        end else if (state_q == S_STEP &&
                     rem_q == NB_STEP'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cause_d = CS_STEP;
        end else if (host_halt) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cause_d = CS_HOST;
        end
      end
      S_FIN: begin
        if (i_cmd_valid && i_cmd == CMD_CLR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    enb_d = (state_d == S_RUN) || (state_d == S_STEP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      enb_q   <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= CS_HOST;
      cnt_q   <= '0;
      rem_q   <= '0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enb_q   <= enb_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
    end
  end

  assign o_pipe_enb   = enb_q;
  assign o_busy       = enb_q;
  assign o_cmd_ready  = (state_q == S_IDLE) || (state_q == S_FIN);
  assign o_done       = done_q;
  assign o_stop_cause = cause_q;
  assign o_cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: directed + random stimulus, reference model
// pushes run-end records, a monitor pops them on each o_done.
module tb_debug_run_ctrl;

  localparam int NB_PC   = 32;
  localparam int NB_STEP = 16;
  localparam int NB_CYC  = 8;
  localparam int CMAX    = (1 << NB_CYC) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic [1:0]         cmd;
  logic [NB_STEP-1:0] step_count;
  logic               brk_enb;
  logic [NB_PC-1:0]   brk_pc;
  logic [NB_PC-1:0]   pc;
  logic               halt_instr;
  logic               pipe_enb, cmd_ready, busy, done;
  logic [1:0]         stop_cause;
  logic [NB_CYC-1:0]  cycle_cnt;

  debug_run_ctrl #(
    .NB_PC(NB_PC), .NB_STEP(NB_STEP), .NB_CYC(NB_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_step_count(step_count), .i_brk_enb(brk_enb),
    .i_brk_pc(brk_pc), .i_pc(pc),
    .i_halt_instr(halt_instr),
    .o_pipe_enb(pipe_enb), .o_cmd_ready(cmd_ready),
    .o_busy(busy), .o_done(done),
    .o_stop_cause(stop_cause), .o_cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cause;
    int cnt;
    int len;
  } rec_t;

  rec_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // reference model: mode 0 idle, 1 free-run, 2 stepping, 3 finished
  int m_mode, m_left, m_cnt, m_len;
  bit m_fresh;

  function automatic void m_reset();
    m_mode = 0; m_left = 0; m_cnt = 0; m_len = 0; m_fresh = 0;
  endfunction

  task automatic cyc(bit v, int c, int sc, bit be,
                     int bp, int p, bit hi);
    int cause;
    rec_t r;
    cmd_valid  = v;
    cmd        = 2'(c);
    step_count = NB_STEP'(sc);
    brk_enb    = be;
    brk_pc     = NB_PC'(bp);
    pc         = NB_PC'(p);
    halt_instr = hi;
    if (m_mode == 1 || m_mode == 2) begin
      m_len++;
      if (m_cnt < CMAX) m_cnt++;
      cause = -1;
      if (hi) cause = 3;
      else if (be && bp == p && !m_fresh) cause = 2;
      else if (m_mode == 2 && m_left == 1) cause = 1;
      else if (v && c == 2) cause = 0;
      m_fresh = 0;
      if (m_mode == 2) m_left--;
      if (cause >= 0) begin
        r.cause = cause; r.cnt = m_cnt; r.len = m_len;
        exp_q.push_back(r);
        m_mode = (cause == 3) ? 3 : 0;
      end
    end else if (m_mode == 0 && v) begin
      if (c == 0 || c == 1) begin
        m_mode  = c + 1;
        m_fresh = 1;
        m_len   = 0;
        m_left  = (sc == 0) ? 1 : sc;
      end else if (c == 3) m_cnt = 0;
    end else if (m_mode == 3 && v && c == 3) begin
      m_cnt  = 0;
      m_mode = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: measures each run's length and checks it on o_done
  int obs = 0;
  always @(negedge clk) begin
    rec_t r;
    if (!rst_n) obs = 0;
    else begin
      if (pipe_enb) obs++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("cause", stop_cause, r.cause);
          chk("cnt_at_done", cycle_cnt, r.cnt);
          chk("run_len", obs, r.len);
        end
        obs = 0;
      end
    end
  end

  initial begin
    int p;
    rst_n = 1'b0;
    cmd_valid = 0; cmd = 0; step_count = 0; brk_enb = 0;
    brk_pc = 0; pc = 0; halt_instr = 0;
    m_reset();
    #1;
    chk("rst_enb", pipe_enb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", stop_cause, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // STEP 3, then STEP 0
    cyc(1, 1, 3, 0, 0, 0, 0);
    idle(5);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(3);
    chk("cnt_after_steps", cycle_cnt, 4);

    // breakpoint at 0x40 with a PC ramp
    cyc(1, 0, 0, 1, 'h40, 0, 0);
    p = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1, 'h40, p, 0);
      if (p < 'h40) p += 4;
    end
    // resume from 0x40: masked first cycle, then ramp on
    cyc(1, 0, 0, 1, 'h40, 'h40, 0);
    cyc(0, 0, 0, 1, 'h40, 'h40, 0);
    for (int i = 1; i < 6; i++)
      cyc(0, 0, 0, 1, 'h40, 'h40 + 4 * i, 0);
    chk("resume_running", pipe_enb, 1);
    cyc(1, 2, 0, 1, 'h40, 'h60, 0);
    idle(3);

    // end of program together with host HALT
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 2, 0, 0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    chk("fin_enb", pipe_enb, 0);
    chk("fin_ready", cmd_ready, 1);
    cyc(1, 3, 0, 0, 0, 0, 0);
    chk("clr_cnt", cycle_cnt, 0);
    cyc(1, 1, 2, 0, 0, 0, 0);
    idle(4);

    // saturation
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(CMAX + 20);
    chk("sat_cnt", cycle_cnt, CMAX);
    cyc(1, 2, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 3, 0, 0, 0, 0, 0);

    // random traffic
    p = 0;
    for (int i = 0; i < 4000; i++) begin
      bit v;
      int c;
      v = ($urandom_range(0, 5) == 0);
      c = $urandom_range(0, 3);
      p = ($urandom_range(0, 15) == 0) ? 4 * $urandom_range(0, 8)
                                      : p + 4;
      cyc(v, c, $urandom_range(0, 6), $urandom_range(0, 1),
          4 * $urandom_range(0, 24), p,
          $urandom_range(0, 60) == 0);
    end
    idle(3);
    chk("final_cnt", cycle_cnt, m_cnt);

    // reset in the middle of a STEP
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 1, 10, 0, 0, 0, 0);
    idle(3);
    chk("midstep_enb", pipe_enb, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_enb", pipe_enb, 0);
    exp_q.delete();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready", cmd_ready, 1);
    chk("rel_cnt", cycle_cnt, 0);
    @(posedge clk);
    #1;
    idle(5);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
# debug_run_ctrl

Run-control sequencer for the MIPS debug unit. It takes host commands decoded from the UART debug link and produces the per-cycle pipeline enable, in one of two modes: free-run, or an exact count of single-cycle steps. It stops on a PC breakpoint, on end-of-program, or on a host HALT command. It also reports why it stopped and keeps a count of executed cycles, which the debug unit uses to trigger register and memory dumps.

## Interface
- NB_PC, 32, width of the PC and breakpoint compare.
- NB_STEP, 16, width of the step-count operand.
- NB_CYC, 32, width of the executed-cycle counter.

- i_clk  in  1  the single clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  a command is present on i_cmd this cycle.
- i_cmd  in  2  command opcode: 00 RUN, 01 STEP, 10 HALT, 11 CLR.
- i_step_count  in  NB_STEP  number of cycles for STEP; sampled when the command is accepted.
- i_brk_enb  in  1  breakpoint compare enable.
- i_brk_pc  in  NB_PC  breakpoint address.
- i_pc  in  NB_PC  current fetch PC from the pipeline.
- i_halt_instr  in  1  HALT instruction has retired; end of program.
- o_pipe_enb  out  NB 1  pipeline enable; registered.
- o_cmd_ready  out  1  RUN, STEP and CLR are accepted this cycle.
- o_busy  out  1  high in RUN and STEP.
- o_done  out  1  one-cycle pulse when a RUN or STEP ends.
- o_stop_cause  out  2  why the last run stopped: 00 host HALT, 01 steps exhausted, 10 breakpoint, 11 end of program.
- o_cycle_cnt  out  NB_CYC  number of cycles in which o_pipe_enb was high; saturating.

## Operation
- States:
  - IDLE: pipeline frozen.
  - RUN: enable held high.
  - STEP: enable high for a counted number of cycles.
  - FINISH: program ended; frozen until cleared.
- Command acceptance:
  - A command is accepted when i_cmd_valid is high and the opcode is legal in the current state.
  - o_cmd_ready is high in IDLE and FINISH.
- Commands in IDLE:
  - RUN → RUN.
  - STEP → STEP, loading remaining = max(i_step_count, 1).
  - CLR → o_cycle_cnt set to 0.
  - HALT → no effect.
- Commands in RUN and STEP:
  - Only HALT is honoured; it moves to IDLE with cause 00.
  - RUN, STEP and CLR are dropped silently.
- Commands in FINISH:
  - CLR sets o_cycle_cnt to 0 and moves to IDLE.
  - RUN, STEP and HALT are ignored.
- Stop events are evaluated only in cycles where o_pipe_enb is high, in this priority order:
  1. i_halt_instr → FINISH, cause 11.
  2. Breakpoint hit (i_brk_enb and i_pc == i_brk_pc) → IDLE, cause 10.
  3. In STEP only, remaining == 1 → IDLE, cause 01.
  4. Host HALT → cause 00.
- A pipeline stop event in the same cycle as a host HALT command wins; the cause is that of the pipeline event.
- Breakpoint masking: the compare is ignored in the first enabled cycle after any RUN or STEP acceptance. This lets the pipeline resume from a PC that equals the breakpoint.
- remaining decrements on every enabled cycle in STEP.
- o_cycle_cnt increments on every cycle in which o_pipe_enb is high and holds at all-ones once it saturates.
- o_stop_cause updates only when o_done pulses and holds its value otherwise.

## Timing
- Reset values: state IDLE, o_pipe_enb 0, o_busy 0, o_done 0, o_stop_cause 00, o_cycle_cnt 0, remaining 0, o_cmd_ready 1.
- Reset mid-run forces these values immediately, without waiting for a clock edge.
- A command accepted at edge t drives o_pipe_enb high from cycle t+1.
- STEP k accepted at t:
  - o_pipe_enb is high for exactly cycles t+1 through t+k.
  - At t+k+1: o_pipe_enb is 0, o_done is 1, o_cmd_ready is 1.
- Any stop event seen in enabled cycle c:
  - The pipeline has executed cycle c.
  - At c+1: o_pipe_enb is 0, o_done pulses for one cycle, o_stop_cause is valid.
- A host HALT accepted at edge t gives o_pipe_enb 0 and o_done 1 at cycle t+1.
- A new RUN or STEP can be accepted in the same cycle that o_done is high.
- o_busy equals o_pipe_enb; both are registered.

## Test plan
- STEP with i_step_count = 3 → o_pipe_enb high for exactly 3 cycles; then o_done = 1, o_stop_cause = 01, o_cycle_cnt = 3.
- STEP with i_step_count = 0 → exactly 1 enabled cycle, cause 01.
- RUN with breakpoint at 0x40 and i_pc ramping by 4 from 0 → enable drops the cycle after i_pc = 0x40, cause 10.
- Resume RUN with i_pc still 0x40 → no immediate stop; the run continues.
- RUN, then i_halt_instr and host HALT asserted in the same cycle → state FINISH, cause 11.
- In FINISH, RUN and STEP → ignored; CLR → o_cycle_cnt = 0, state IDLE.
- RUN with NB_CYC = 4 for 20 cycles → o_cycle_cnt saturates at 15.
- Assert i_rst_n low mid-STEP → o_pipe_enb = 0 immediately, without a clock edge.
- Release reset → o_cmd_ready = 1 and all counters at 0.
